// File: rtl/control_unit_mc_if.sv
// Instruction handshake and control-strobe bundle between the issuer and control_unit_mc.
// Widths follow the control unit's SIZE / ADDR_W / CNT_W parameters.
interface control_unit_mc_if #(
  parameter int unsigned SIZE   = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned CNT_W  = 16
);
  logic              instr_valid;
  logic [SIZE-1:0]   instruction;
  logic              instr_ready;
  logic              rf_write_enable;
  logic [ADDR_W-1:0] rf_write_addr;
  logic              rf_wb_sel;
  logic [ADDR_W-1:0] rf_addr_a;
  logic [ADDR_W-1:0] rf_addr_b;
  logic [1:0]        alu_op;
  logic              alu_src_imm;
  logic              dm_read;
  logic              dm_write_enable;
  logic              done;
  logic              illegal;
  logic [CNT_W-1:0]  retired_count;
  logic [CNT_W-1:0]  illegal_count;

  modport master (
    output instr_valid, instruction,
    input  instr_ready, rf_write_enable, rf_write_addr, rf_wb_sel, rf_addr_a, rf_addr_b,
           alu_op, alu_src_imm, dm_read, dm_write_enable, done, illegal,
           retired_count, illegal_count
  );

  modport slave (
    input  instr_valid, instruction,
    output instr_ready, rf_write_enable, rf_write_addr, rf_wb_sel, rf_addr_a, rf_addr_b,
           alu_op, alu_src_imm, dm_read, dm_write_enable, done, illegal,
           retired_count, illegal_count
  );
endinterface

// File: rtl/control_unit_mc.sv
// Multi-cycle control FSM (IDLE/DECODE/EXEC/MEM/WB) with Moore-decoded strobes.
// Retired/illegal counters are compiled in only when CONTROL_UNIT_PERF_EN is defined.
module control_unit_mc #(
  parameter int unsigned WORDSIZE = 64,
  parameter int unsigned SIZE     = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned CNT_W    = 16
) (
  input logic              clk,
  input logic              rst,
  control_unit_mc_if.slave bus
);
  localparam int unsigned FieldW = 4 + 3 * ADDR_W;

  localparam logic [3:0] OpLw  = 4'd0;
  localparam logic [3:0] OpSw  = 4'd1;
  localparam logic [3:0] OpSub = 4'd3;
  localparam logic [3:0] OpAnd = 4'd4;
  localparam logic [3:0] OpOr  = 4'd5;
  localparam logic [3:0] OpNop = 4'd6;

  typedef enum logic [2:0] {StIdle, StDecode, StExec, StMem, StWb} state_e;

  state_e            state_q, state_d;
  logic [FieldW-1:0] instr_q, instr_d;
  logic [3:0]        opcode;
  logic [ADDR_W-1:0] rd, rs1, rs2;
  logic              is_mem;

  logic              instr_ready, rf_write_enable, rf_wb_sel, alu_src_imm;
  logic              dm_read, dm_write_enable, done, illegal;
  logic [ADDR_W-1:0] rf_write_addr, rf_addr_a, rf_addr_b;
  logic [1:0]        alu_op;

  // The immediate is consumed by the datapath only, so just the decoded fields are latched.
  assign opcode = instr_q[3:0];
  assign rd     = instr_q[4 +: ADDR_W];
  assign rs1    = instr_q[4 + ADDR_W +: ADDR_W];
  assign rs2    = instr_q[4 + 2 * ADDR_W +: ADDR_W];
  assign is_mem = (opcode == OpLw) || (opcode == OpSw);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    instr_d         = instr_q;
    instr_ready     = 1'b0;
    rf_write_enable = 1'b0;
    rf_write_addr   = '0;
    rf_wb_sel       = 1'b0;
    rf_addr_a       = '0;
    rf_addr_b       = '0;
    alu_op          = 2'd0;
    alu_src_imm     = 1'b0;
    dm_read         = 1'b0;
    dm_write_enable = 1'b0;
    done            = 1'b0;
    illegal         = 1'b0;
    unique case (state_q)
      StIdle: begin
        instr_ready = 1'b1;
        if (bus.instr_valid) begin
          instr_d = bus.instruction[FieldW-1:0];
          state_d = StDecode;
        end
      end
      StDecode: begin
        rf_addr_a = rs1;
        rf_addr_b = rs2;
        if (opcode == OpNop) begin
          done    = 1'b1;
          state_d = StIdle;
        end else if (opcode > OpNop) begin
          done    = 1'b1;
          illegal = 1'b1;
          state_d = StIdle;
        end else begin
          state_d = StExec;
        end
      end
      StExec: begin
        rf_addr_a = rs1;
        rf_addr_b = rs2;
        case (opcode)
          OpSub:   alu_op = 2'd1;
          OpAnd:   alu_op = 2'd2;
          OpOr:    alu_op = 2'd3;
          default: alu_op = 2'd0;
        endcase
        alu_src_imm = is_mem;
        state_d     = is_mem ? StMem : StWb;
      end
      StMem: begin
        rf_addr_a = rs1;
        rf_addr_b = rs2;
        if (opcode == OpLw) begin
          dm_read = 1'b1;
          state_d = StWb;
        end else begin
          dm_write_enable = 1'b1;
          done            = 1'b1;
          state_d         = StIdle;
        end
      end
      StWb: begin
        rf_addr_a       = rs1;
        rf_addr_b       = rs2;
        rf_write_enable = (rd != '0);
        rf_write_addr   = rd;
        rf_wb_sel       = (opcode == OpLw);
        done            = 1'b1;
        state_d         = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.instr_ready     = instr_ready;
  assign bus.rf_write_enable = rf_write_enable;
  assign bus.rf_write_addr   = rf_write_addr;
  assign bus.rf_wb_sel       = rf_wb_sel;
  assign bus.rf_addr_a       = rf_addr_a;
  assign bus.rf_addr_b       = rf_addr_b;
  assign bus.alu_op          = alu_op;
  assign bus.alu_src_imm     = alu_src_imm;
  assign bus.dm_read         = dm_read;
  assign bus.dm_write_enable = dm_write_enable;
  assign bus.done            = done;
  assign bus.illegal         = illegal;

`ifdef CONTROL_UNIT_PERF_EN
  logic [CNT_W-1:0] retired_q, illegal_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      retired_q <= '0;
      illegal_q <= '0;
    end else begin
      if (done)    retired_q <= retired_q + CNT_W'(1);
      if (illegal) illegal_q <= illegal_q + CNT_W'(1);
    end
  end

  assign bus.retired_count = retired_q;
  assign bus.illegal_count = illegal_q;
`else
  assign bus.retired_count = '0;
  assign bus.illegal_count = '0;
`endif

  if (SIZE > FieldW) begin : g_imm_unused
    logic unused_imm;
    assign unused_imm = ^bus.instruction[SIZE-1:FieldW];
  end

  logic [31:0] unused_wordsize;
  assign unused_wordsize = WORDSIZE;
endmodule
